// File: rtl/npu_mem_loader_pkg.sv
// npu_loader_pkg: loader state encoding, default widths and region-size helpers.
package npu_loader_pkg;

   localparam int ADDR_W_DEFAULT = 16;
   localparam int DATA_W_DEFAULT = 32;
   localparam int COUNT_W        = 32;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CALC,
      ST_LOAD_IN,
      ST_LOAD_W,
      ST_KICK,
      ST_WAIT_DONE,
      ST_ERR
   } loader_state_e;

   // 32-bit products hold the largest encodable layer (7*7*4095*255) exactly,
   // so the range check sees the true count rather than a wrapped one.
   function automatic logic [COUNT_W-1:0] words_in(input logic [13:0] ic,
                                                   input logic [5:0]  h,
                                                   input logic [5:0]  w);
      return COUNT_W'(h) * COUNT_W'(w) * COUNT_W'(ic >> 2);
   endfunction

   function automatic logic [COUNT_W-1:0] words_w(input logic [2:0]  k,
                                                  input logic [13:0] ic,
                                                  input logic [7:0]  oc);
      return COUNT_W'(k) * COUNT_W'(k) * COUNT_W'(ic >> 2) * COUNT_W'(oc);
   endfunction

endpackage

// File: rtl/npu_mem_loader_if.sv
// npu_mem_loader_if: host word stream (valid/ready/data/last) into the loader.
interface npu_mem_loader_if
   import npu_loader_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEFAULT
);

   logic              s_valid;
   logic              s_ready;
   logic [DATA_W-1:0] s_data;
   logic              s_last;

   modport master (output s_valid, s_data, s_last, input s_ready);
   modport slave  (input s_valid, s_data, s_last, output s_ready);

endinterface

// File: rtl/npu_mem_loader_addr_gen.sv
// loader_addr_gen: word-index counter, terminal-count compare and registered SRAM A-ports.
module loader_addr_gen
   import npu_loader_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEFAULT,
   parameter int DATA_W = DATA_W_DEFAULT
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              clr,
   input  logic              adv,
   input  logic              sel,
   input  logic [ADDR_W-1:0] last_idx,
   input  logic [DATA_W-1:0] din,
   output logic              tc,
   output logic              input_ena,
   output logic              input_wea,
   output logic [ADDR_W-1:0] input_addra,
   output logic [DATA_W-1:0] input_dina,
   output logic              weight_ena,
   output logic              weight_wea,
   output logic [ADDR_W-1:0] weight_addra,
   output logic [DATA_W-1:0] weight_dina
);

   logic [ADDR_W-1:0] idx;

   assign tc = (idx == last_idx);

   // NOTE: all state here uses <= so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         idx          <= '0;
         input_ena    <= 1'b0;
         input_wea    <= 1'b0;
         input_addra  <= '0;
         input_dina   <= '0;
         weight_ena   <= 1'b0;
         weight_wea   <= 1'b0;
         weight_addra <= '0;
         weight_dina  <= '0;
      end else begin
         input_ena  <= adv & ~sel;
         input_wea  <= adv & ~sel;
         weight_ena <= adv & sel;
         weight_wea <= adv & sel;
         if (adv && !sel) begin
            input_addra <= idx;
            input_dina  <= din;
         end
         if (adv && sel) begin
            weight_addra <= idx;
            weight_dina  <= din;
         end
         // Wrapping at terminal count is what clears the index on the region switch.
         if (clr)
            idx <= '0;
         else if (adv)
            idx <= tc ? '0 : idx + 1'b1;
      end
   end

endmodule

// File: rtl/npu_mem_loader.sv
// npu_mem_loader: fills input then weight SRAM from a host stream, kicks the conv core.
// Optional running checksum of accepted words under LOADER_CHECKSUM_EN.
module npu_mem_loader
   import npu_loader_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEFAULT,
   parameter int DATA_W = DATA_W_DEFAULT
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              load_start,
   input  logic [2:0]        K,
   input  logic [13:0]       IC,
   input  logic [5:0]        IMG_H,
   input  logic [5:0]        IMG_W,
   input  logic [7:0]        OC,
   npu_mem_loader_if.slave   s,
   output logic              input_ena,
   output logic              input_wea,
   output logic [ADDR_W-1:0] input_addra,
   output logic [DATA_W-1:0] input_dina,
   output logic              weight_ena,
   output logic              weight_wea,
   output logic [ADDR_W-1:0] weight_addra,
   output logic [DATA_W-1:0] weight_dina,
   output logic              npu_start,
   input  logic              npu_done,
   output logic              load_done,
   output logic              busy,
   output logic              err
`ifdef LOADER_CHECKSUM_EN
   ,
   output logic [31:0]       checksum
`endif
);

   localparam logic [COUNT_W:0] MAX_WORDS = {{COUNT_W{1'b0}}, 1'b1} << ADDR_W;

   loader_state_e      state;
   logic [2:0]         k_q;
   logic [13:0]        ic_q;
   logic [5:0]         h_q;
   logic [5:0]         w_q;
   logic [7:0]         oc_q;
   logic               done_q;
   logic [COUNT_W-1:0] n_in;
   logic [COUNT_W-1:0] n_w;
   logic               cfg_bad;
   logic               hs;
   logic               tc;
   logic               sel_w;
   logic [ADDR_W-1:0]  last_idx;

   assign n_in    = words_in(ic_q, h_q, w_q);
   assign n_w     = words_w(k_q, ic_q, oc_q);
   assign cfg_bad = (n_in == '0) || (n_w == '0) ||
                    ({1'b0, n_in} > MAX_WORDS) || ({1'b0, n_w} > MAX_WORDS) ||
                    (ic_q[1:0] != 2'b00);

   assign hs       = s.s_valid & s.s_ready;
   assign sel_w    = (state == ST_LOAD_W);
   assign last_idx = sel_w ? ADDR_W'(n_w - 1'b1) : ADDR_W'(n_in - 1'b1);

   loader_addr_gen #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_addr_gen (
      .clk          (clk),
      .resetn       (resetn),
      .clr          (state == ST_CALC),
      .adv          (hs),
      .sel          (sel_w),
      .last_idx     (last_idx),
      .din          (s.s_data),
      .tc           (tc),
      .input_ena    (input_ena),
      .input_wea    (input_wea),
      .input_addra  (input_addra),
      .input_dina   (input_dina),
      .weight_ena   (weight_ena),
      .weight_wea   (weight_wea),
      .weight_addra (weight_addra),
      .weight_dina  (weight_dina)
   );

   // Outputs are registered, so each is set on the transition into the state it belongs to.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state     <= ST_IDLE;
         s.s_ready <= 1'b0;
         npu_start <= 1'b0;
         load_done <= 1'b0;
         busy      <= 1'b0;
         err       <= 1'b0;
         done_q    <= 1'b0;
         k_q       <= '0;
         ic_q      <= '0;
         h_q       <= '0;
         w_q       <= '0;
         oc_q      <= '0;
      end else begin
         npu_start <= 1'b0;
         load_done <= 1'b0;
         done_q    <= npu_done;
         case (state)
            ST_IDLE: begin
               if (load_start) begin
                  k_q   <= K;
                  ic_q  <= IC;
                  h_q   <= IMG_H;
                  w_q   <= IMG_W;
                  oc_q  <= OC;
                  err   <= 1'b0;
                  busy  <= 1'b1;
                  state <= ST_CALC;
               end
            end
            ST_CALC: begin
               if (cfg_bad) begin
                  err   <= 1'b1;
                  state <= ST_ERR;
               end else begin
                  s.s_ready <= 1'b1;
                  state     <= ST_LOAD_IN;
               end
            end
            ST_LOAD_IN: begin
               if (hs) begin
                  if (s.s_last) begin
                     s.s_ready <= 1'b0;
                     err       <= 1'b1;
                     state     <= ST_ERR;
                  end else if (tc) begin
                     state <= ST_LOAD_W;
                  end
               end
            end
            ST_LOAD_W: begin
               // s_last must coincide exactly with the final weight word.
               if (hs && (s.s_last || tc)) begin
                  s.s_ready <= 1'b0;
                  if (s.s_last && tc) begin
                     state <= ST_KICK;
                  end else begin
                     err   <= 1'b1;
                     state <= ST_ERR;
                  end
               end
            end
            ST_KICK: begin
               npu_start <= 1'b1;
               state     <= ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
               if (npu_done && !done_q) begin
                  load_done <= 1'b1;
                  busy      <= 1'b0;
                  state     <= ST_IDLE;
               end
            end
            ST_ERR: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               s.s_ready <= 1'b0;
               busy      <= 1'b0;
               state     <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef LOADER_CHECKSUM_EN
   always_ff @(posedge clk) begin
      if (!resetn)
         checksum <= '0;
      else if (state == ST_IDLE && load_start)
         checksum <= '0;
      else if (hs)
         checksum <= checksum + 32'(s.s_data);
   end
`endif

endmodule

// File: tb/tb_npu_mem_loader.sv
// tb_npu_mem_loader: randomized stream stimulus with a write scoreboard and a
// count-level reference model of the loader.
module tb_npu_mem_loader;

   localparam int AW = 16;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic          load_start = 1'b0;
   logic [2:0]    K = '0;
   logic [13:0]   IC = '0;
   logic [5:0]    IMG_H = '0;
   logic [5:0]    IMG_W = '0;
   logic [7:0]    OC = '0;
   logic          input_ena, input_wea, weight_ena, weight_wea;
   logic [AW-1:0] input_addra, weight_addra;
   logic [31:0]   input_dina, weight_dina;
   logic          npu_start;
   logic          npu_done = 1'b0;
   logic          load_done, busy, err;
`ifdef LOADER_CHECKSUM_EN
   logic [31:0]   checksum;
`endif

   npu_mem_loader_if s_if ();

   npu_mem_loader dut (
      .clk          (clk),
      .resetn       (resetn),
      .load_start   (load_start),
      .K            (K),
      .IC           (IC),
      .IMG_H        (IMG_H),
      .IMG_W        (IMG_W),
      .OC           (OC),
      .s            (s_if),
      .input_ena    (input_ena),
      .input_wea    (input_wea),
      .input_addra  (input_addra),
      .input_dina   (input_dina),
      .weight_ena   (weight_ena),
      .weight_wea   (weight_wea),
      .weight_addra (weight_addra),
      .weight_dina  (weight_dina),
      .npu_start    (npu_start),
      .npu_done     (npu_done),
      .load_done    (load_done),
      .busy         (busy),
      .err          (err)
`ifdef LOADER_CHECKSUM_EN
      ,
      .checksum     (checksum)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          wport;
      int          addr;
      logic [31:0] data;
   } wr_t;

   wr_t         exp_q[$];
   logic [31:0] fixed_q[$];
   logic [31:0] sum_model = '0;
   int          n_checks = 0;
   int          n_errors = 0;
   int          start_cnt = 0;
   bit          rdy_seen = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: region sizes straight from the layer arithmetic.
   function automatic int model_n_in(int ic, int h, int w);
      return h * w * (ic / 4);
   endfunction

   function automatic int model_n_w(int k, int ic, int oc);
      return k * k * (ic / 4) * oc;
   endfunction

   // Monitor: every presented A-port write must match the oldest expected one.
   initial begin : monitor
      wr_t         e;
      bit          wp;
      int          a;
      logic [31:0] d;
      forever begin
         @(negedge clk);
         if (npu_start === 1'b1) start_cnt++;
         if (s_if.s_ready === 1'b1) rdy_seen = 1'b1;
         if (input_ena === 1'b1 || weight_ena === 1'b1 || input_wea === 1'b1 || weight_wea === 1'b1) begin
            wp = weight_ena;
            a  = wp ? int'(weight_addra) : int'(input_addra);
            d  = wp ? weight_dina : input_dina;
            check("wea_matches_ena", 32'({input_wea, weight_wea}), 32'({input_ena, weight_ena}));
            check("single_port", 32'(input_ena & weight_ena), 0);
            check("write_expected", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("wr_port", 32'(wp), 32'(e.wport));
               check("wr_addr", 32'(a), 32'(e.addr));
               check("wr_data", d, e.data);
            end
         end
      end
   end

   task automatic check_all_zero(input string tag);
      check({tag, "_ctrl"}, 32'({s_if.s_ready, input_ena, input_wea, weight_ena, weight_wea,
                                 npu_start, load_done, busy, err}), 0);
      check({tag, "_addr"}, {input_addra, weight_addra}, 0);
      check({tag, "_in_din"}, input_dina, 0);
      check({tag, "_w_din"}, weight_dina, 0);
`ifdef LOADER_CHECKSUM_EN
      check({tag, "_checksum"}, checksum, 0);
`endif
   endtask

   // Entered at a negedge; returns at the negedge of the second cycle after load_start.
   task automatic start_load(input int k, input int ic, input int h, input int w, input int oc);
      K = 3'(k); IC = 14'(ic); IMG_H = 6'(h); IMG_W = 6'(w); OC = 8'(oc);
      load_start = 1'b1;
      sum_model  = '0;
      @(negedge clk);
      load_start = 1'b0;
      K = 3'($urandom); IC = 14'($urandom); IMG_H = 6'($urandom); IMG_W = 6'($urandom); OC = 8'($urandom);
      check("busy_in_calc", 32'(busy), 1);
      check("err_cleared", 32'(err), 0);
      check("ready_in_calc", 32'(s_if.s_ready), 0);
`ifdef LOADER_CHECKSUM_EN
      check("checksum_cleared", checksum, 0);
`endif
      @(negedge clk);
   endtask

   task automatic drive_words(input int total, input int n_in, input int last_at,
                              input int valid_pct, input bit poke, output int cyc);
      int          i;
      logic [31:0] d;
      i   = 0;
      cyc = 0;
      while (i < total && cyc < 20 * total + 50) begin
         d = (i < fixed_q.size()) ? fixed_q[i] : $urandom;
         s_if.s_valid = (int'($urandom_range(99)) < valid_pct);
         s_if.s_data  = d;
         s_if.s_last  = (i == last_at);
         if (poke) load_start = 1'($urandom_range(1));
         if (s_if.s_valid && s_if.s_ready) begin
            exp_q.push_back('{wport: (i >= n_in), addr: (i >= n_in) ? i - n_in : i, data: d});
            sum_model += d;
            i++;
         end
         @(negedge clk);
         cyc++;
      end
      check("stream_complete", 32'(i), 32'(total));
      s_if.s_valid = 1'b0;
      s_if.s_last  = 1'b0;
      load_start   = 1'b0;
   endtask

   task automatic finish_load();
      int s0;
      int t;
      s0 = start_cnt;
      check("no_start_with_last_write", 32'(npu_start), 0);
      @(negedge clk);
      check("start_after_last_write", 32'(npu_start), 1);
      check("writes_drained", 32'(exp_q.size()), 0);
      @(negedge clk);
      check("start_single_pulse", 32'(npu_start), 0);
      check("busy_wait_done", 32'(busy), 1);
      repeat ($urandom_range(3)) @(negedge clk);
      npu_done = 1'b1;
      t = 0;
      while (load_done !== 1'b1 && t < 10) begin
         @(negedge clk);
         t++;
      end
      check("load_done_latency", 32'(t), 1);
      check("busy_after_done", 32'(busy), 0);
      check("err_after_done", 32'(err), 0);
      check("start_count", 32'(start_cnt), 32'(s0 + 1));
`ifdef LOADER_CHECKSUM_EN
      check("checksum", checksum, sum_model);
`endif
      @(negedge clk);
      check("load_done_pulse", 32'(load_done), 0);
      npu_done = 1'b0;
      @(negedge clk);
   endtask

   task automatic run_good(input int k, input int ic, input int h, input int w, input int oc,
                           input int pct, input bit poke);
      int n_in, n_w, cyc;
      n_in = model_n_in(ic, h, w);
      n_w  = model_n_w(k, ic, oc);
      start_load(k, ic, h, w, oc);
      check("ready_two_cycles", 32'(s_if.s_ready), 1);
      drive_words(n_in + n_w, n_in, n_in + n_w - 1, pct, poke, cyc);
      if (pct == 100) check("full_throughput", 32'(cyc), 32'(n_in + n_w));
      finish_load();
   endtask

   task automatic bad_cfg(input int k, input int ic, input int h, input int w, input int oc);
      int s0;
      s0       = start_cnt;
      rdy_seen = 1'b0;
      start_load(k, ic, h, w, oc);
      check("cfg_err_set", 32'(err), 1);
      check("cfg_err_busy", 32'(busy), 1);
      @(negedge clk);
      check("cfg_err_idle", 32'(busy), 0);
      check("cfg_err_sticky", 32'(err), 1);
      repeat (4) @(negedge clk);
      check("cfg_err_no_ready", 32'(rdy_seen), 0);
      check("cfg_err_no_start", 32'(start_cnt), 32'(s0));
   endtask

   task automatic run_bad_stream(input int k, input int ic, input int h, input int w, input int oc,
                                 input int total, input int last_at);
      int s0, cyc, n_in;
      s0   = start_cnt;
      n_in = model_n_in(ic, h, w);
      start_load(k, ic, h, w, oc);
      check("ready_two_cycles", 32'(s_if.s_ready), 1);
      drive_words(total, n_in, last_at, 100, 1'b0, cyc);
      check("last_err_set", 32'(err), 1);
      check("last_err_ready", 32'(s_if.s_ready), 0);
      @(negedge clk);
      check("last_err_idle", 32'(busy), 0);
      check("last_err_drained", 32'(exp_q.size()), 0);
      repeat (4) @(negedge clk);
      check("last_err_no_start", 32'(start_cnt), 32'(s0));
   endtask

   initial begin : main
      int cyc;
      s_if.s_valid = 1'b0;
      s_if.s_data  = '0;
      s_if.s_last  = 1'b0;
      repeat (2) @(negedge clk);
      check_all_zero("reset");
      resetn = 1'b1;
      @(negedge clk);

      run_good(3, 8, 32, 32, 16, 100, 1'b0);
      run_good(3, 8, 32, 32, 16, 50, 1'b0);

      bad_cfg(3, 6, 32, 32, 16);
      bad_cfg(1, 4, 1, 1, 0);
      bad_cfg(7, 4092, 1, 1, 255);
      bad_cfg(1, 0, 4, 4, 1);

      run_bad_stream(3, 8, 32, 32, 16, 100, 99);
      run_bad_stream(1, 4, 2, 2, 2, 4, 3);
      run_bad_stream(1, 4, 2, 2, 2, 6, -1);

      // Reset partway into the weight region, then a clean restart.
      start_load(3, 8, 32, 32, 16);
      check("ready_two_cycles", 32'(s_if.s_ready), 1);
      drive_words(2048 + 40, 2048, -1, 100, 1'b0, cyc);
      resetn = 1'b0;
      @(negedge clk);
      check_all_zero("mid_reset");
      check("mid_reset_drained", 32'(exp_q.size()), 0);
      resetn = 1'b1;
      @(negedge clk);
      run_good(3, 8, 32, 32, 16, 100, 1'b0);

      fixed_q = '{32'h0000_0001, 32'hFFFF_FFFF};
      run_good(1, 4, 1, 1, 1, 100, 1'b0);
      fixed_q.delete();

      for (int r = 0; r < 4; r++)
         run_good($urandom_range(1, 3), 4 * $urandom_range(1, 3), $urandom_range(1, 6),
                  $urandom_range(1, 6), $urandom_range(1, 4), $urandom_range(30, 100), 1'b1);

      check("final_queue_empty", 32'(exp_q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin : watchdog
      #5_000_000;
      $display("FAIL watchdog: got no completion, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/npu_mem_loader.md
# npu_mem_loader

Host-side writer for the NPU's input and weight SRAM A-ports. It accepts a 32-bit valid/ready word stream and sizes each region from the layer configuration (K, IC, IMG_H, IMG_W, OC). It fills the input memory, then the weight memory, pulses `start` to the conv core and reports completion when the core's `done` arrives. It is the writer end of the memory interface whose output B-port is read back after `done`.

## Interface
- `ADDR_W`, 16: SRAM address width for both memories.
- `DATA_W`, 32: word width; four int8 lanes per word.
- `clk` in 1: sole clock; input and weight A-port clocks are tied to it.
- `resetn` in 1: synchronous, active-low reset.
- `load_start` in 1: one-cycle request; ignored unless the block is IDLE.
- `K` in 3, `IC` in 14, `IMG_H` in 6, `IMG_W` in 6, `OC` in 8: layer configuration, sampled on `load_start`.
- `s_valid` in 1, `s_ready` out 1, `s_data` in 32, `s_last` in 1: host word stream.
- `input_ena`, `input_wea` out 1; `input_addra` out ADDR_W; `input_dina` out 32: input SRAM A-port.
- `weight_ena`, `weight_wea` out 1; `weight_addra` out ADDR_W; `weight_dina` out 32: weight SRAM A-port.
- `npu_start` out 1: one-cycle start pulse to the conv core.
- `npu_done` in 1: done from the conv core.
- `load_done` out 1: one-cycle pulse after `npu_done` is seen.
- `busy` out 1: high in every state except IDLE.
- `err` out 1: sticky configuration/stream error flag; cleared by the next accepted `load_start`.
- `checksum` out 32: present only under `LOADER_CHECKSUM_EN`.

## Operation
- States: IDLE → CALC → LOAD_IN → LOAD_W → KICK → WAIT_DONE → IDLE.
  - ERR is entered from CALC, LOAD_IN or LOAD_W and returns to IDLE.
- **IDLE.** On `load_start`, register the configuration, clear `err`, go to CALC.
- **CALC** (one cycle). Compute both word counts:
  - `n_in = IMG_H*IMG_W*(IC>>2)`.
  - `n_w = K*K*(IC>>2)*OC`.
  - Intermediate widths are wide enough for no overflow before comparison.
  - Go to ERR if either count is 0, if either count > 2^ADDR_W, or if IC[1:0] != 0.
- **LOAD_IN.** `s_ready` = 1. Each handshake (`s_valid & s_ready`) writes `s_data` to `input_addra` = word index; the index runs 0..n_in-1.
  - After handshake n_in: go to LOAD_W with the index cleared.
- **LOAD_W.** Same as LOAD_IN, writing to the weight port, index 0..n_w-1.
  - After handshake n_w: go to KICK.
- **`s_last`.** Must be high on exactly the final weight word. High on any earlier word, or low on the final word, → ERR.
  - The offending word is still written; `err` is set.
- **KICK.** `npu_start` = 1 for one cycle, then go to WAIT_DONE.
- **WAIT_DONE.** Edge-detect `npu_done`. On the rising edge: `load_done` pulses one cycle, go to IDLE.
- **ERR** (one cycle). `err` = 1 (sticky), go to IDLE. No `npu_start` is issued.
- **`s_ready`.** 0 outside LOAD_IN and LOAD_W.
- **`load_start` while busy.** Ignored; no queuing.

## Timing
- **Reset.** `resetn` low at any clock edge forces IDLE. On that edge, every output clears to 0: `s_ready`, all ena/wea/addr/din, `npu_start`, `load_done`, `busy`, `err`, `checksum`.
  - Reset mid-load abandons the partial load. Memory contents are not scrubbed.
- **SRAM write latency.** A-port outputs are registered. A handshake at edge t drives ena = wea = 1 with addr/din during cycle t+1, and the write lands at edge t+1.
  - ena and wea are 0 on idle cycles.
- **Throughput.** One word per cycle with `s_valid` held high.
- **Region switch.** The LOAD_IN → LOAD_W transition inserts no bubble.
- **Start timing.** `npu_start` asserts the cycle after the final weight write has been presented.
- **Minimum turnaround.** `load_start` to first `s_ready` = 2 cycles (IDLE→CALC, CALC→LOAD_IN).

## Configuration
- `LOADER_CHECKSUM_EN` defined:
  - `checksum` port exists.
  - It is cleared on `load_start` and adds each accepted `s_data`, modulo 2^32, across both regions.
  - It holds its value after the load for host comparison.
- Undefined: the port and adder are absent. All other behaviour is identical.

## Structure
- Package `npu_loader_pkg` holds:
  - the state enum;
  - the `ADDR_W`/`DATA_W` defaults;
  - function `words_in(IC, H, W)`;
  - function `words_w(K, IC, OC)`.
- Sub-module `loader_addr_gen` owns the word-index counter, the terminal-count compare and the registered A-port outputs. It is instantiated once, with its port select driven by the FSM.

## Test plan
- IC=8, K=3, IMG_H=IMG_W=32, OC=16, continuous `s_valid`, `s_last` on word 2336:
  - 2048 input writes at addresses 0..2047, then 288 weight writes at 0..287;
  - `npu_start` pulses once;
  - `npu_done` → `load_done` pulse; `err` = 0.
- Same config with `s_valid` toggling 50%: identical memory contents, no dropped or duplicated addresses.
- IC=6 → `err` = 1 two cycles after `load_start`; `s_ready` never high; no `npu_start`.
- `s_last` on word 100: `err` = 1, return to IDLE, no `npu_start`.
- `resetn` low for 1 cycle mid-LOAD_W: next cycle all outputs 0 and `busy` = 0; a fresh `load_start` restarts at input address 0.
- `LOADER_CHECKSUM_EN`, K=1, IC=4, IMG_H=IMG_W=1, OC=1, data 0x00000001 and 0xFFFFFFFF: `checksum` = 0x00000000; one input write, one weight write.
